// File: rtl/eth_phy_10g_pkg.sv
// rtl/eth_phy_10g_pkg.sv - shared constants, types and helpers for the eth_phy_10g receive path
package eth_phy_10g_pkg;

  localparam int DATA_W = 64;
  localparam int HDR_W  = 2;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam int LOCK_WINDOW    = 64;
  localparam int LOCK_ERR_LIMIT = 16;
  localparam int BER_ERR_LIMIT  = 16;

  typedef enum logic [1:0] {
    SLIP_IDLE = 2'd0,
    SLIP_HIGH = 2'd1,
    SLIP_LOW  = 2'd2
  } slip_state_t;

  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_sync_if.sv
// rtl/eth_phy_10g_rx_sync_if.sv - SERDES-facing and link-status signals of the 10GBASE-R block sync
interface eth_phy_10g_rx_sync_if;
  import eth_phy_10g_pkg::*;

  logic [DATA_W-1:0] serdes_rx_data;
  logic [HDR_W-1:0]  serdes_rx_hdr;
  logic              serdes_rx_bitslip;
  logic              serdes_rx_reset_req;
  logic              rx_block_lock;
  logic              rx_high_ber;
  logic              rx_status;
  logic              rx_bad_block;
  logic [6:0]        rx_error_count;
  logic [DATA_W-1:0] rx_data;
  logic [HDR_W-1:0]  rx_hdr;

  modport master (
    output serdes_rx_data, serdes_rx_hdr,
    input  serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber,
    input  rx_status, rx_bad_block, rx_error_count, rx_data, rx_hdr
  );

  modport slave (
    input  serdes_rx_data, serdes_rx_hdr,
    output serdes_rx_bitslip, serdes_rx_reset_req, rx_block_lock, rx_high_ber,
    output rx_status, rx_bad_block, rx_error_count, rx_data, rx_hdr
  );

endinterface

// File: rtl/eth_phy_10g_rx_ber_mon.sv
// rtl/eth_phy_10g_rx_ber_mon.sv - 125 us BER window, error count, link status and SERDES watchdog
module eth_phy_10g_rx_ber_mon
  import eth_phy_10g_pkg::*;
#(
  parameter int COUNT_125US = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hdr_bad,
  input  logic       block_lock,
  output logic       high_ber,
  output logic       status,
  output logic       reset_req,
  output logic [6:0] error_count
);

  localparam int WIN_CW = $clog2(COUNT_125US);

  logic [WIN_CW-1:0] win_cnt;
  logic              win_end;
  logic [4:0]        ber_cnt;
  logic [4:0]        ber_cnt_d;
  logic              ber_hit;
  logic              status_seen;
  logic              bad_win;

  assign win_end = (win_cnt == WIN_CW'(COUNT_125US - 1));

  // The header arriving on the closing cycle is folded into that window.
  always_comb begin
    ber_cnt_d = ber_cnt;
    if (hdr_bad && block_lock && (ber_cnt != 5'h1f)) begin
      ber_cnt_d = ber_cnt + 5'd1;
    end
  end

  assign ber_hit = (ber_cnt_d >= 5'(BER_ERR_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      ber_cnt     <= '0;
      high_ber    <= 1'b0;
      status      <= 1'b0;
      reset_req   <= 1'b0;
      error_count <= '0;
      status_seen <= 1'b0;
      bad_win     <= 1'b0;
    end else begin
      reset_req <= 1'b0;
      status    <= block_lock && !high_ber;
      if (win_end) begin
        win_cnt     <= '0;
        ber_cnt     <= '0;
        high_ber    <= ber_hit;
        error_count <= {2'b00, ber_cnt_d};
        status_seen <= 1'b0;
        // Two back-to-back windows without a good link ask the SERDES to reset.
        if (status_seen || status) begin
          bad_win <= 1'b0;
        end else if (bad_win) begin
          bad_win   <= 1'b0;
          reset_req <= 1'b1;
        end else begin
          bad_win <= 1'b1;
        end
      end else begin
        win_cnt     <= win_cnt + WIN_CW'(1);
        ber_cnt     <= ber_cnt_d;
        status_seen <= status_seen | status;
        if (ber_hit) begin
          high_ber <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_sync.sv
// rtl/eth_phy_10g_rx_sync.sv - 64b/66b block lock and bitslip control with BER/link-health monitoring
module eth_phy_10g_rx_sync
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH          = 64,
  parameter int HDR_WIDTH           = 2,
  parameter int BIT_REVERSE         = 0,
  parameter int RX_SERDES_PIPELINE  = 0,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8,
  parameter int COUNT_125US         = 125
) (
  input  logic           rx_clk,
  input  logic           rx_rst,
  eth_phy_10g_rx_sync_if.slave rx
);

  localparam int SLIP_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                            BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
  localparam int SLIP_CW  = $clog2(SLIP_MAX + 1);

  logic [DATA_WIDTH-1:0] data_p;
  logic [HDR_WIDTH-1:0]  hdr_p;
  logic                  hdr_vld;
  logic [DATA_WIDTH-1:0] data_r;
  logic [HDR_WIDTH-1:0]  hdr_r;
  logic                  hdr_bad;
  logic                  hdr_good;

  generate
    if (RX_SERDES_PIPELINE == 0) begin : g_no_pipe
      assign data_p  = rx.serdes_rx_data;
      assign hdr_p   = rx.serdes_rx_hdr;
      assign hdr_vld = 1'b1;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0]         data_q [RX_SERDES_PIPELINE];
      logic [HDR_WIDTH-1:0]          hdr_q  [RX_SERDES_PIPELINE];
      logic [RX_SERDES_PIPELINE-1:0] vld_q;

      // vld_q keeps the reset contents of the pipeline from being judged as headers.
      always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
          for (int i = 0; i < RX_SERDES_PIPELINE; i++) begin
            data_q[i] <= '0;
            hdr_q[i]  <= '0;
            vld_q[i]  <= 1'b0;
          end
        end else begin
          data_q[0] <= rx.serdes_rx_data;
          hdr_q[0]  <= rx.serdes_rx_hdr;
          vld_q[0]  <= 1'b1;
          for (int i = 1; i < RX_SERDES_PIPELINE; i++) begin
            data_q[i] <= data_q[i-1];
            hdr_q[i]  <= hdr_q[i-1];
            vld_q[i]  <= vld_q[i-1];
          end
        end
      end

      assign data_p  = data_q[RX_SERDES_PIPELINE-1];
      assign hdr_p   = hdr_q[RX_SERDES_PIPELINE-1];
      assign hdr_vld = vld_q[RX_SERDES_PIPELINE-1];
    end
  endgenerate

  always_comb begin
    data_r = data_p;
    hdr_r  = hdr_p;
    if (BIT_REVERSE != 0) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        data_r[i] = data_p[DATA_WIDTH-1-i];
      end
      for (int i = 0; i < HDR_WIDTH; i++) begin
        hdr_r[i] = hdr_p[HDR_WIDTH-1-i];
      end
    end
  end

  assign rx.rx_data = data_r;
  assign rx.rx_hdr  = hdr_r;
  assign hdr_bad    = hdr_vld && !hdr_is_valid(hdr_r);
  assign hdr_good   = hdr_vld && hdr_is_valid(hdr_r);

  logic        block_lock, lock_d;
  logic [5:0]  sh_cnt, sh_cnt_d;
  logic [4:0]  sh_inv_cnt, sh_inv_d;
  logic        slip_req;
  logic        bad_block;

  slip_state_t          slip_state, slip_state_d;
  logic [SLIP_CW-1:0]   slip_cnt, slip_cnt_d;
  logic                 slip_last_low;
  logic                 slip_ready;

  // The last mandatory low cycle already accepts a new header, so back-to-back slips
  // are spaced HIGH+LOW cycles apart.
  assign slip_last_low = (slip_state == SLIP_LOW) &&
                         (slip_cnt == SLIP_CW'(BITSLIP_LOW_CYCLES - 1));
  assign slip_ready    = (slip_state == SLIP_IDLE) || slip_last_low;

  always_comb begin
    lock_d   = block_lock;
    sh_cnt_d = sh_cnt;
    sh_inv_d = sh_inv_cnt;
    slip_req = 1'b0;
    if (!block_lock) begin
      if (!slip_ready) begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
      end else if (hdr_bad) begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
        slip_req = 1'b1;
      end else if (hdr_good) begin
        if (sh_cnt == 6'(LOCK_WINDOW - 1)) begin
          lock_d   = 1'b1;
          sh_cnt_d = '0;
          sh_inv_d = '0;
        end else begin
          sh_cnt_d = sh_cnt + 6'd1;
        end
      end
    end else if (hdr_vld) begin
      if (hdr_bad && (sh_inv_cnt == 5'(LOCK_ERR_LIMIT - 1))) begin
        lock_d   = 1'b0;
        sh_cnt_d = '0;
        sh_inv_d = '0;
        slip_req = 1'b1;
      end else if (sh_cnt == 6'(LOCK_WINDOW - 1)) begin
        sh_cnt_d = '0;
        sh_inv_d = '0;
      end else begin
        sh_cnt_d = sh_cnt + 6'd1;
        if (hdr_bad) begin
          sh_inv_d = sh_inv_cnt + 5'd1;
        end
      end
    end
  end

  always_comb begin
    slip_state_d = slip_state;
    slip_cnt_d   = slip_cnt;
    case (slip_state)
      SLIP_IDLE: begin
        if (slip_req) begin
          slip_state_d = SLIP_HIGH;
          slip_cnt_d   = '0;
        end
      end
      SLIP_HIGH: begin
        if (slip_cnt == SLIP_CW'(BITSLIP_HIGH_CYCLES - 1)) begin
          slip_state_d = SLIP_LOW;
          slip_cnt_d   = '0;
        end else begin
          slip_cnt_d = slip_cnt + SLIP_CW'(1);
        end
      end
      SLIP_LOW: begin
        if (slip_last_low) begin
          slip_state_d = slip_req ? SLIP_HIGH : SLIP_IDLE;
          slip_cnt_d   = '0;
        end else begin
          slip_cnt_d = slip_cnt + SLIP_CW'(1);
        end
      end
      default: begin
        slip_state_d = SLIP_IDLE;
        slip_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      block_lock <= 1'b0;
      sh_cnt     <= '0;
      sh_inv_cnt <= '0;
      slip_state <= SLIP_IDLE;
      slip_cnt   <= '0;
      bad_block  <= 1'b0;
    end else begin
      block_lock <= lock_d;
      sh_cnt     <= sh_cnt_d;
      sh_inv_cnt <= sh_inv_d;
      slip_state <= slip_state_d;
      slip_cnt   <= slip_cnt_d;
      bad_block  <= hdr_bad;
    end
  end

  assign rx.serdes_rx_bitslip = (slip_state == SLIP_HIGH);
  assign rx.rx_block_lock     = block_lock;
  assign rx.rx_bad_block      = bad_block;

  eth_phy_10g_rx_ber_mon #(
    .COUNT_125US (COUNT_125US)
  ) u_ber_mon (
    .clk         (rx_clk),
    .rst         (rx_rst),
    .hdr_bad     (hdr_bad),
    .block_lock  (block_lock),
    .high_ber    (rx.rx_high_ber),
    .status      (rx.rx_status),
    .reset_req   (rx.serdes_rx_reset_req),
    .error_count (rx.rx_error_count)
  );

endmodule

// File: tb/tb_eth_phy_10g_rx_sync.sv
// tb/tb_eth_phy_10g_rx_sync.sv - directed vector bench for eth_phy_10g_rx_sync
module tb_eth_phy_10g_rx_sync;

  logic rx_clk = 1'b0;
  logic rx_rst = 1'b1;

  eth_phy_10g_rx_sync_if rx();

  eth_phy_10g_rx_sync dut (
    .rx_clk (rx_clk),
    .rx_rst (rx_rst),
    .rx     (rx)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [1:0] hdr;
    logic       lock;
    logic       status;
    logic       bitslip;
    logic       bad;
  } vec_t;

  vec_t        vecs [68];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] last_data = '0;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cycle(input logic [1:0] h);
    rx.serdes_rx_hdr  = h;
    last_data         = {$urandom, $urandom};
    rx.serdes_rx_data = last_data;
    @(posedge rx_clk);
    @(negedge rx_clk);
    cyc++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_lock"},      rx.rx_block_lock,       0);
    chk({tag, "_status"},    rx.rx_status,           0);
    chk({tag, "_bitslip"},   rx.serdes_rx_bitslip,   0);
    chk({tag, "_bad"},       rx.rx_bad_block,        0);
    chk({tag, "_high_ber"},  rx.rx_high_ber,         0);
    chk({tag, "_err_cnt"},   rx.rx_error_count,      0);
    chk({tag, "_reset_req"}, rx.serdes_rx_reset_req, 0);
  endtask

  task automatic do_reset();
    rx_rst = 1'b1;
    cycle(2'b01);
    cycle(2'b01);
    chk_all_zero("rst");
    rx_rst = 1'b0;
    cyc    = 0;
  endtask

  task automatic lock_up(input string tag);
    for (int i = 0; i < 64; i++) begin
      cycle((i % 2 == 1) ? 2'b10 : 2'b01);
      chk({tag, "_lock"}, rx.rx_block_lock, (i == 63) ? 1 : 0);
      chk({tag, "_bitslip"}, rx.serdes_rx_bitslip, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      vecs[i] = '{hdr: ((i % 2 == 1) ? 2'b10 : 2'b01), lock: (i == 63),
                  status: 1'b0, bitslip: 1'b0, bad: 1'b0};
    end
    vecs[64] = '{hdr: 2'b01, lock: 1'b1, status: 1'b1, bitslip: 1'b0, bad: 1'b0};
    vecs[65] = '{hdr: 2'b00, lock: 1'b1, status: 1'b1, bitslip: 1'b0, bad: 1'b1};
    vecs[66] = '{hdr: 2'b11, lock: 1'b1, status: 1'b1, bitslip: 1'b0, bad: 1'b1};
    vecs[67] = '{hdr: 2'b10, lock: 1'b1, status: 1'b1, bitslip: 1'b0, bad: 1'b0};

    // Initial lock from reset, driven from the vector table.
    do_reset();
    for (int i = 0; i < 68; i++) begin
      cycle(vecs[i].hdr);
      chk("tbl_lock",    rx.rx_block_lock,     vecs[i].lock);
      chk("tbl_status",  rx.rx_status,         vecs[i].status);
      chk("tbl_bitslip", rx.serdes_rx_bitslip, vecs[i].bitslip);
      chk("tbl_bad",     rx.rx_bad_block,      vecs[i].bad);
      chk("tbl_data",    int'(rx.rx_data == last_data), 1);
    end

    // 15 invalid headers in one lock window never drop lock.
    do_reset();
    lock_up("s2");
    for (int j = 0; j < 64; j++) begin
      cycle((j % 4 == 0 && j < 60) ? 2'b00 : 2'b10);
      chk("s2_lock", rx.rx_block_lock, 1);
      chk("s2_high_ber", rx.rx_high_ber, 0);
      if (cyc == 125) chk("s2_err_cnt", rx.rx_error_count, 15);
    end

    // 16th invalid in one lock window drops lock, one slip, then relock.
    do_reset();
    lock_up("s3");
    for (int j = 0; j < 46; j++) begin
      cycle((j % 3 == 0) ? 2'b00 : 2'b01);
      chk("s3_lock_hold", rx.rx_block_lock, (j < 45) ? 1 : 0);
    end
    chk("s3_slip_high", rx.serdes_rx_bitslip, 1);
    for (int n = 1; n <= 72; n++) begin
      cycle(2'b10);
      chk("s3_slip_low", rx.serdes_rx_bitslip, 0);
      chk("s3_relock", rx.rx_block_lock, (n == 72) ? 1 : 0);
    end

    // Constant 2'b11 while unlocked: periodic slips and watchdog reset request.
    do_reset();
    for (int k = 1; k <= 260; k++) begin
      cycle(2'b11);
      chk("s4_bitslip",   rx.serdes_rx_bitslip,   (k % 9 == 1) ? 1 : 0);
      chk("s4_lock",      rx.rx_block_lock,       0);
      chk("s4_bad",       rx.rx_bad_block,        1);
      chk("s4_reset_req", rx.serdes_rx_reset_req, (k == 250) ? 1 : 0);
    end

    // 16 invalid in one BER window, split across two lock windows.
    do_reset();
    lock_up("s5");
    for (int k = 65; k <= 501; k++) begin
      logic bad;
      bad = (k >= 130 && k <= 235 && (k - 130) % 7 == 0) || k == 500 || k == 501;
      cycle(bad ? 2'b11 : 2'b01);
      chk("s5_lock", rx.rx_block_lock, 1);
      if (k == 125) chk("s5_err_w1", rx.rx_error_count, 0);
      if (k == 250) begin
        chk("s5_high_ber_w2", rx.rx_high_ber, 1);
        chk("s5_err_w2",      rx.rx_error_count, 16);
        chk("s5_status_w2",   rx.rx_status, 0);
      end
      if (k == 375) begin
        chk("s5_high_ber_w3", rx.rx_high_ber, 0);
        chk("s5_err_w3",      rx.rx_error_count, 0);
      end
      if (k == 376) chk("s5_status_w3", rx.rx_status, 1);
      if (k == 500) begin
        chk("s5_err_edge",      rx.rx_error_count, 1);
        chk("s5_high_ber_edge", rx.rx_high_ber, 0);
      end
      if (k == 501) chk("s5_err_hold", rx.rx_error_count, 1);
    end

    // Reset while locked clears everything; relock repeats.
    do_reset();
    lock_up("s6");
    cycle(2'b01);
    cycle(2'b00);
    chk("s6_bad_pre", rx.rx_bad_block, 1);
    chk("s6_lock_pre", rx.rx_block_lock, 1);
    rx_rst = 1'b1;
    cycle(2'b10);
    chk_all_zero("s6_midrst");
    rx_rst = 1'b0;
    cyc    = 0;
    lock_up("s6_relock");
    cycle(2'b10);
    chk("s6_status", rx.rx_status, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
